uart_rx_top: RTL and testbench
==============================

# uart_rx_top

UART receiver: the receive-side counterpart of the team's UART transmitter, sharing its frame format and parity options. It oversamples the serial line `RX_IN` at `prescale` clocks per bit and majority-votes each bit at mid-bit. It deserializes LSB-first data, optionally checks parity, and checks the stop bit. Each accepted byte is presented on `P_DATA` with a one-cycle `data_valid` strobe. It sits between the pad-side line synchronizer and the system's byte consumer.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `CLK` input 1: the block's single clock; `RX_IN` is already synchronized to it.
- `RST` input 1: reset, synchronous to `CLK`, active-high.
- `RX_IN` input 1: serial line; idle high.
- `prescale` input 6: clocks per bit.
  - Legal values are 8, 16 and 32; any other value behaves as 8.
  - Latched on start detection.
- `PAR_EN` input 1: 1 means the frame carries a parity bit. Latched on start detection.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd. Latched on start detection.
- `P_DATA` output `DATA_WIDTH`: last accepted byte. Holds its value until the next accepted byte.
- `data_valid` output 1: one-cycle strobe when `P_DATA` updates.
- `parity_error` output 1: one-cycle strobe; the frame is dropped.
- `stop_error` output 1: one-cycle strobe; the frame is dropped.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit timing:
  - The edge counter runs 0..`prescale`-1 within each bit.
  - The bit counter runs 0..`DATA_WIDTH`-1 in DATA.
- Sampling: three samples per bit, taken at edge counts P/2-1, P/2 and P/2+1 (P = latched prescale). The bit value is the majority of the three.
- IDLE:
  - `RX_IN`=0 moves to START. Counters are cleared and the configuration inputs are latched.
  - That detection cycle is edge count 0 of the start bit.
- START: at edge count P-1:
  - If the majority bit is 0, move to DATA.
  - If it is 1 (glitch), return to IDLE. No output strobe is asserted.
- DATA:
  - Shift each majority bit in LSB-first.
  - After bit `DATA_WIDTH`-1, go to PARITY if `PAR_EN` is set, otherwise to STOP.
- PARITY: the expected bit is XOR of the data, inverted when `PAR_TYP`=1. A mismatch sets an internal flag.
- STOP: the majority bit must be 1. At edge count P-1, return to IDLE and register the results:
  - Parity flag set: `parity_error`=1.
  - Stop bit 0: `stop_error`=1.
  - Both conditions may assert together.
  - Neither condition: `data_valid`=1 and `P_DATA` is loaded.
- Back-to-back frames: if `RX_IN`=0 in the first IDLE cycle after STOP, that cycle is the start detection of the next frame. No idle gap is required.
- `prescale`, `PAR_EN` and `PAR_TYP` changes mid-frame are ignored until the next start detection.

## Timing
- Reset values: FSM in IDLE, all counters 0, `P_DATA`=0, `data_valid`=0, `parity_error`=0, `stop_error`=0.
- Reset asserted mid-frame:
  - The frame is discarded and no strobe is asserted.
  - Reception resumes with the first falling edge after `RST` deasserts.
- Latency, with start detection at cycle 0 and N = 1 + `DATA_WIDTH` + `PAR_EN` + 1 bits per frame:
  - The strobes are registered high in cycle N·P.
  - They stay high for exactly one cycle.
  - `P_DATA` is valid in the same cycle as `data_valid`.
- Error strobes are mutually exclusive with `data_valid`.
- There is no backpressure. The consumer must accept each byte on its `data_valid` cycle.

## Configuration
- With `UART_RX_PARITY_EN` defined: the PARITY state and the parity check are present, and `PAR_EN`/`PAR_TYP` behave as specified.
- Without it:
  - `PAR_EN` and `PAR_TYP` are ignored, and the frame is always start + data + stop.
  - `parity_error` is tied to 0.
  - No parity logic is synthesized.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - Legal prescale constants 8/16/32.
  - Parity-type encodings (EVEN=0, ODD=1).
- One natural sub-module, `rx_data_sampler`:
  - Contains the edge counter and the three-sample majority vote.
  - Emits the sampled bit and a bit-done pulse to the FSM.

## Test plan
- `prescale`=8, no parity, frame 0xA5 → `data_valid` in cycle 80, `P_DATA`=0xA5, no error strobes.
- `prescale`=16, even parity, 0x3C with parity bit 0 → `data_valid` in cycle 176, `P_DATA`=0x3C. Repeat with parity bit 1 → `parity_error` in cycle 176, no `data_valid`, `P_DATA` unchanged.
- `prescale`=8, odd parity, 0xFF with correct parity and a stop bit of 0 → `stop_error` pulse only.
- `RX_IN` low for 2 cycles in IDLE at `prescale`=8 → return to IDLE, no strobes; a following valid 0x5A frame is received correctly.
- Two frames back-to-back, 0x01 then 0x80 at `prescale`=32, second start bit immediately after the first stop bit → two `data_valid` pulses 320 cycles apart with the correct bytes.
- `RST` asserted during DATA bit 4 → all outputs 0 in the next cycle; the next frame 0x33 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and constants (FSM states, prescale values,
//                parity encodings).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Unsupported oversampling ratios fall back to the slowest-clock setting.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        if (p == PRESCALE_16 || p == PRESCALE_32) begin
            return p;
        end
        return PRESCALE_8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_data_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_data_sampler
//  Description : Per-bit edge counter and three-sample mid-bit majority vote.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_data_sampler
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       start_i,
    input  logic       active_i,
    input  logic [5:0] prescale_i,
    output logic       bit_o,
    output logic       bit_done_o
);

    logic [5:0] cnt_q, cnt_d;
    logic [2:0] smp_q, smp_d;
    logic [5:0] w_half;
    logic [5:0] w_last;

    assign w_half = {1'b0, prescale_i[5:1]};
    assign w_last = prescale_i - 6'd1;

    // The start-detection cycle itself is edge count 0, so counting resumes at 1.
    always_comb begin
        cnt_d = '0;
        smp_d = smp_q;
        if (start_i) begin
            cnt_d = 6'd1;
            smp_d = '0;
        end else if (active_i) begin
            cnt_d = (cnt_q == w_last) ? 6'd0 : cnt_q + 6'd1;
            if (cnt_q == w_half - 6'd1) smp_d[0] = rx_i;
            if (cnt_q == w_half)        smp_d[1] = rx_i;
            if (cnt_q == w_half + 6'd1) smp_d[2] = rx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            smp_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end

    assign bit_o      = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign bit_done_o = active_i && (cnt_q == w_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_top.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_top
//  Description : Oversampling UART receiver, LSB-first, optional parity
//                (compiled in with UART_RX_PARITY_EN) and stop-bit check.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [5:0]            prescale_q, prescale_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  valid_q, valid_d;
    logic                  serr_q, serr_d;
    logic                  w_start;
    logic                  w_active;
    logic                  w_bit;
    logic                  w_bit_done;

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic par_flag_q, par_flag_d;
    logic perr_q, perr_d;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

    assign w_active = (state_q != RX_IDLE);

    rx_data_sampler u_sampler (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rx_i       (RX_IN),
        .start_i    (w_start),
        .active_i   (w_active),
        .prescale_i (prescale_q),
        .bit_o      (w_bit),
        .bit_done_o (w_bit_done)
    );

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        valid_d    = 1'b0;
        serr_d     = 1'b0;
        w_start    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_flag_d = par_flag_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                if (!RX_IN) begin
                    w_start    = 1'b1;
                    state_d    = RX_START;
                    prescale_d = legal_prescale(prescale);
                    bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_flag_d = 1'b0;
`endif
                end
            end
            RX_START: begin
                // A high majority at the end of the start bit means a line glitch.
                if (w_bit_done) begin
                    state_d = w_bit ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_bit_done) begin
                    shift_d = {w_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = par_en_q ? RX_PARITY : RX_STOP;
`else
                        state_d   = RX_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (w_bit_done) begin
                    par_flag_d = (w_bit != ((^shift_q) ^ (par_typ_q == PARITY_ODD)));
                    state_d    = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (w_bit_done) begin
                    state_d = RX_IDLE;
                    serr_d  = ~w_bit;
`ifdef UART_RX_PARITY_EN
                    perr_d  = par_flag_q;
                    if (w_bit && !par_flag_q) begin
                        valid_d  = 1'b1;
                        p_data_d = shift_q;
                    end
`else
                    if (w_bit) begin
                        valid_d  = 1'b1;
                        p_data_d = shift_q;
                    end
`endif
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RX_IDLE;
            prescale_q <= PRESCALE_8;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            valid_q    <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            valid_q    <= valid_d;
            serr_q     <= serr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q   <= 1'b0;
            par_typ_q  <= PARITY_EVEN;
            par_flag_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_flag_q <= par_flag_d;
            perr_q     <= perr_d;
        end
    end
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

    assign P_DATA     = p_data_q;
    assign data_valid = valid_q;
    assign stop_error = serr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_top
//  Description : Frame-level model of uart_rx_top with a per-cycle output check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_top;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale_r = 6'd8;
    logic       par_en_r = 1'b0;
    logic       par_typ_r = 1'b0;
    logic [7:0] p_data;
    logic       data_valid, parity_error, stop_error;

    uart_rx_top #(.DATA_WIDTH(8)) dut (
        .CLK          (clk),
        .RST          (rst),
        .RX_IN        (rx_in),
        .prescale     (prescale_r),
        .PAR_EN       (par_en_r),
        .PAR_TYP      (par_typ_r),
        .P_DATA       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        bit          v;
        bit          pe;
        bit          se;
        logic [7:0]  d;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned obs_v_cyc[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          checking = 1'b0;
    logic [7:0]  model_pdata = 8'h00;
    int unsigned last_s_cyc = 0;
    bit          e_v, e_pe, e_se;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame model: frame length and strobe cycle follow from the latched config.
    task automatic send_frame(input logic [5:0] p, input bit pen, input bit ptyp,
                              input logic [7:0] d, input bit flip, input bit stopb,
                              output int unsigned c0);
        int  eff_p;
        bit  eff_par;
        int  n;
        ev_t e;
        eff_p   = (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
        eff_par = pen && PAR_BUILT;
        n       = 1 + 8 + (eff_par ? 1 : 0) + 1;
        prescale_r = p;
        par_en_r   = pen;
        par_typ_r  = ptyp;
        rx_in      = 1'b0;
        c0         = cyc;
        e.cyc = c0 + n * eff_p;
        e.pe  = eff_par && flip;
        e.se  = !stopb;
        e.v   = !e.pe && !e.se;
        e.d   = d;
        exp_q.push_back(e);
        hold(eff_p);
        prescale_r = 6'd5;
        par_en_r   = ~pen;
        par_typ_r  = ~ptyp;
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            hold(eff_p);
        end
        if (eff_par) begin
            rx_in = (^d) ^ ptyp ^ flip;
            hold(eff_p);
        end
        rx_in = stopb;
        hold(eff_p);
        rx_in = 1'b1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            e_v = 1'b0; e_pe = 1'b0; e_se = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_event", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e_v  = exp_q[0].v;
                e_pe = exp_q[0].pe;
                e_se = exp_q[0].se;
                if (exp_q[0].v) model_pdata = exp_q[0].d;
                void'(exp_q.pop_front());
            end
            chk("data_valid", data_valid, e_v);
            chk("parity_error", parity_error, e_pe);
            chk("stop_error", stop_error, e_se);
            chk("P_DATA", p_data, model_pdata);
            if (data_valid) obs_v_cyc.push_back(cyc);
            if (data_valid || parity_error || stop_error) last_s_cyc = cyc;
        end
    end

    initial begin
        int unsigned c0, c1, snap;
        hold(3);
        chk("reset_P_DATA", p_data, 8'h00);
        chk("reset_valid", data_valid, 1'b0);
        chk("reset_perr", parity_error, 1'b0);
        chk("reset_serr", stop_error, 1'b0);
        rst = 1'b0;
        checking = 1'b1;
        hold(4);

        send_frame(6'd8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, c0);
        hold(4);
        chk("a5_latency", last_s_cyc - c0, 80);
        chk("a5_data", p_data, 8'hA5);

        send_frame(6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, c0);
        hold(4);
        chk("3c_latency", last_s_cyc - c0, PAR_BUILT ? 176 : 160);
        chk("3c_data", p_data, 8'h3C);

        send_frame(6'd8, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, c0);
        hold(4);
        send_frame(6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, c0);
        hold(4);
        chk("3c_perr_latency", last_s_cyc - c0, PAR_BUILT ? 176 : 160);
        chk("3c_perr_hold", p_data, PAR_BUILT ? 8'h11 : 8'h3C);

        send_frame(6'd8, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, c0);
        hold(4);
        chk("ff_stop_latency", last_s_cyc - c0, PAR_BUILT ? 88 : 80);

        snap = last_s_cyc;
        prescale_r = 6'd8;
        rx_in = 1'b0;
        hold(2);
        rx_in = 1'b1;
        hold(12);
        chk("glitch_no_strobe", last_s_cyc, snap);
        send_frame(6'd8, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, c0);
        hold(4);
        chk("5a_data", p_data, 8'h5A);

        send_frame(6'd12, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, c0);
        hold(4);
        chk("illegal_prescale_latency", last_s_cyc - c0, 80);

        send_frame(6'd32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, c0);
        send_frame(6'd32, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, c1);
        hold(4);
        chk("b2b_start_gap", c1 - c0, 320);
        chk("b2b_valid_gap", obs_v_cyc[obs_v_cyc.size()-1] - obs_v_cyc[obs_v_cyc.size()-2], 320);
        chk("b2b_data", p_data, 8'h80);

        // Abort a frame during data bit 4.
        prescale_r = 6'd8;
        par_en_r   = 1'b0;
        rx_in      = 1'b0;
        hold(8);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            hold(8);
        end
        rx_in = 1'b1;
        hold(3);
        rst = 1'b1;
        hold(1);
        model_pdata = 8'h00;
        chk("rst_mid_P_DATA", p_data, 8'h00);
        hold(3);
        rst = 1'b0;
        hold(5);
        send_frame(6'd8, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, c0);
        hold(4);
        chk("33_data", p_data, 8'h33);
        chk("33_latency", last_s_cyc - c0, 80);

        hold(10);
        chk("events_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
